// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline register with load-use hazard detection and branch squash.
// Sits directly downstream of the fetch stage.
//
// * Latches the fetched instruction and PC. If the incoming values are
//   applied before posedge N, they appear on id_* after posedge N.
// * Detects a load-use hazard against the LDUR currently in EX. On a hazard
//   it holds id_* for one cycle, drops pc_write so fetch holds its PC, and
//   raises id_bubble so decode zeroes its control signals.
// * After a taken branch it replaces FLUSH_CYCLES fetched slots with
//   NOP_INSTR (id_valid=0), so decode never sees wrong-path instructions.
//
// Parameters
//   NOP_INSTR     encoding injected on bubble/flush (ADD X31,X31,X31)
//   FLUSH_CYCLES  number of fetched slots squashed after br_taken (1..3)
//
// Ports
//   clk         in   1   clock, all state updates on posedge
//   reset       in   1   synchronous, active-high
//   if_instr    in   32  instruction from fetch
//   if_pc       in   64  PC of if_instr
//   br_taken    in   1   EX-stage branch resolved taken (1-cycle pulse)
//   ex_memread  in   1   instruction in EX is LDUR
//   ex_rd       in   5   destination register of the instruction in EX
//   id_instr    out  32  instruction presented to decode
//   id_pc       out  64  PC presented to decode
//   id_valid    out  1   1 = real instruction, 0 = bubble/NOP
//   pc_write    out  1   0 = fetch must hold its PC this cycle
//   id_bubble   out  1   1 = decode must zero its control signals
//   stall_cnt   out  32  perf: load-use stall cycles
//   flush_cnt   out  32  perf: squashed slots
//
// Build option
//   IFID_PERF_EN  when defined, stall_cnt/flush_cnt are 32-bit wrapping
//                 counters cleared by reset. When undefined, the counters
//                 are not built and both outputs are tied to zero.
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR    = 32'h8B1F03FF,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [63:0] if_pc,
  input  logic        br_taken,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        id_valid,
  output logic        pc_write,
  output logic        id_bubble,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Remaining squash slots loaded on the branch edge; the branch cycle itself
  // is the first squashed slot, hence the minus one.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] squash_cnt;
  logic       hazard;

  // True when the instruction reads register rd as a source. Rn and Rm are
  // always treated as sources (a false positive only costs one stall); Rt is
  // a source only for stores (STUR) and compare-and-branch (CBZ).
  function automatic logic reads_reg(input logic [31:0] instr,
                                     input logic [4:0]  rd);
    logic rt_is_src;
    rt_is_src = (instr[31:21] == 11'h7C0) || (instr[31:24] == 8'hB4);
    return (instr[9:5] == rd) || (instr[20:16] == rd) ||
           (rt_is_src && (instr[4:0] == rd));
  endfunction

  // X31 is the zero register in this context, so a load to it never
  // produces a value that decode could depend on.
  always_comb begin
    hazard    = ex_memread && (ex_rd != 5'd31) && id_valid &&
                reads_reg(id_instr, ex_rd);
    // Only stall from RUN: the held instruction in STALL must not stall
    // again, and a taken branch overrides the stall entirely.
    id_bubble = hazard && (state == RUN) && !br_taken;
    pc_write  = !id_bubble;
  end

  // ---- IF -> ID register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      squash_cnt <= 2'd0;
      id_instr   <= NOP_INSTR;
      id_pc      <= 64'd0;
      id_valid   <= 1'b0;
    end else if (br_taken) begin
      // A taken branch restarts the squash from any state and cancels a
      // pending stall. The PC still follows fetch for trace purposes; it is
      // meaningless while id_valid is low.
      id_instr   <= NOP_INSTR;
      id_pc      <= if_pc;
      id_valid   <= 1'b0;
      squash_cnt <= FLUSH_INIT;
      state      <= (FLUSH_INIT == 2'd0) ? RUN : FLUSH;
    end else begin
      case (state)
        FLUSH: begin
          id_instr   <= NOP_INSTR;
          id_pc      <= if_pc;
          id_valid   <= 1'b0;
          squash_cnt <= squash_cnt - 2'd1;
          if (squash_cnt == 2'd1) begin
            state <= RUN;
          end
        end
        STALL: begin
          // Exactly one held cycle; fetch held its PC, so if_* now carries
          // the instruction that was blocked during the hazard cycle.
          id_instr <= if_instr;
          id_pc    <= if_pc;
          id_valid <= 1'b1;
          state    <= RUN;
        end
        default: begin
          if (id_bubble) begin
            state <= STALL;
          end else begin
            id_instr <= if_instr;
            id_pc    <= if_pc;
            id_valid <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Squashed slots are the branch cycle plus every FLUSH cycle; a branch
  // arriving during FLUSH counts once, not twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (id_bubble) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (br_taken || (state == FLUSH)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
